// File: rtl/div_unit_if.sv
// Request/response bundle for the iterative divider.
// Both channels move data on a rising edge where valid and ready are high together.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete at once.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  div_unit_if.slave   bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]      op_q;
  logic            qneg_q, rneg_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] quo_q, div_q, rem_q, result_q;

  logic            is_signed, a_neg, b_neg, div_zero, overflow, accept, last_step;
  logic [XLEN-1:0] a_mag, b_mag, quo_step, rem_step, q_final, r_final;
  logic [XLEN+1:0] trial;

  assign is_signed = ~bus.req_op[0];
  assign a_neg     = is_signed & bus.req_a[XLEN-1];
  assign b_neg     = is_signed & bus.req_b[XLEN-1];
  assign a_mag     = a_neg ? -bus.req_a : bus.req_a;
  assign b_mag     = b_neg ? -bus.req_b : bus.req_b;
  assign div_zero  = (bus.req_b == '0);
  assign overflow  = is_signed && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_b == '1);
  assign accept    = (state_q == IDLE) && bus.req_valid && !flush;
  assign last_step = (state_q == CALC) && (cnt_q == 6'd31);

  // Two extra bits: the shifted partial remainder can reach 2^(XLEN+1)-1.
  assign trial = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, div_q};

  always_comb begin
    rem_step = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    quo_step = {quo_q[XLEN-2:0], 1'b0};
    if (!trial[XLEN+1]) begin
      rem_step = trial[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign q_final = qneg_q ? -quo_step : quo_step;
  assign r_final = rneg_q ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush outranks both accept and response consumption.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.req_valid) state_d = (div_zero || overflow) ? DONE : CALC;
        CALC:    if (last_step) state_d = DONE;
        DONE:    if (bus.resp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= bus.req_op;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      cnt_q  <= '0;
      quo_q  <= a_mag;
      div_q  <= b_mag;
      rem_q  <= '0;
      if (div_zero) begin
        result_q <= bus.req_op[1] ? bus.req_a : '1;
      end else if (overflow) begin
        result_q <= bus.req_op[1] ? '0 : bus.req_a;
      end
    end else if (state_q == CALC) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q + 6'd1;
      if (last_step) begin
        result_q <= op_q[1] ? r_final : q_final;
      end
    end
  end

  // req_ready is gated by rst so it reads low throughout reset.
  assign bus.req_ready   = (state_q == IDLE) && rst;
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp_result = (state_q == DONE) ? result_q : '0;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, random ops against an arithmetic model,
// and hand sequences for stall, flush and asynchronous reset.
module tb_div_unit;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] state_dbg;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Latency counts rising edges from the accept edge (inclusive) to resp_valid.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      r   = op[1] ? a : 32'hFFFF_FFFF;
      lat = 1;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r   = op[1] ? 32'd0 : 32'h8000_0000;
      lat = 1;
    end else begin
      lat = 33;
      if (!op[0]) begin
        if (op[1]) r = sa % sb;
        else       r = sa / sb;
      end else begin
        if (op[1]) r = a % b;
        else       r = a / b;
      end
    end
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    wait_ready(tag);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat, input int hold, input string tag);
    int lat;
    logic [31:0] held;
    exp_q.push_back(exp_r);
    start_req(op, a, b, tag);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    held = bus.resp_result;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = (i == 3);
      bus.req_b     = 32'd0;
      @(posedge clk); #1;
      check({tag, " stall result"}, bus.resp_result, held);
      check({tag, " stall valid"}, {31'd0, bus.resp_valid}, 32'd1);
      check({tag, " stall req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    check({tag, " result"}, held, exp_q.pop_front());
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, " post valid"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, " post result"}, bus.resp_result, 32'd0);
    check({tag, " post req_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic watch_silent(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    check({tag, " no stale resp"}, seen, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b, r_exp;
    int          r_lat;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[9]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[10] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[11] = '{2'b00, 32'd0,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[12] = '{2'b11, 32'd0,          32'd0,          32'd0,          1};
    vecs[13] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[14] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[15] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33};

    rst            = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    #2;
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset resp_result", bus.resp_result, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("first cycle req_ready", {31'd0, bus.req_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0, $sformatf("vec%0d", i));
    end

    // Held response with a rejected request pulse in the middle.
    run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, 10, "stall");

    // Flush during iteration, then a clean follow-up request.
    start_req(2'b01, 32'd100, 32'd7, "flush_calc");
    repeat (14) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc idle", {31'd0, bus.req_ready}, 32'd1);
    check("flush_calc valid", {31'd0, bus.resp_valid}, 32'd0);
    watch_silent(40, "flush_calc");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0, "after_flush");

    // Flush wins over consumption of a pending response.
    start_req(2'b01, 32'd5, 32'd0, "flush_done");
    check("flush_done pending", {31'd0, bus.resp_valid}, 32'd1);
    flush = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.resp_ready = 1'b0;
    check("flush_done valid", {31'd0, bus.resp_valid}, 32'd0);
    check("flush_done idle", {31'd0, bus.req_ready}, 32'd1);

    // Flush wins over accept.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_b     = 32'd0;
    flush         = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    check("flush_accept valid", {31'd0, bus.resp_valid}, 32'd0);
    check("flush_accept idle", {31'd0, bus.req_ready}, 32'd1);

    // Asynchronous reset mid-iteration.
    start_req(2'b01, 32'd100, 32'd7, "rst_calc");
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_calc req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_calc resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_calc resp_result", bus.resp_result, 32'd0);
    @(posedge clk);
    #4 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_calc release ready", {31'd0, bus.req_ready}, 32'd1);
    watch_silent(40, "rst_calc");

    // Asynchronous reset while a response is pending.
    start_req(2'b10, 32'd9, 32'd0, "rst_done");
    check("rst_done pending", {31'd0, bus.resp_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_done resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #4 rst = 1'b1;
    watch_silent(5, "rst_done");

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 16));
        2:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        3:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        default: r_b = $urandom;
      endcase
      model(r_op, r_a, r_b, r_exp, r_lat);
      run_op(r_op, r_a, r_b, r_exp, r_lat, $urandom_range(0, 2), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
